// File: rtl/data_gen_if.sv
// Command/data bundle between the data generator and its controller/display.
interface data_gen_if;
  logic        tick;
  logic        start_f;
  logic        start_t;
  logic        stop;
  logic        update;
  logic [2:0]  prog_in;
  logic [1:0]  gen_mod;
  logic [2:0]  prog;
  logic [15:0] data_2;
  logic        data_valid;

  // Controller side: issues commands, observes generated data.
  modport master (
    output tick, start_f, start_t, stop, update, prog_in,
    input  gen_mod, prog, data_2, data_valid
  );

  // Generator side.
  modport slave (
    input  tick, start_f, start_t, stop, update, prog_in,
    output gen_mod, prog, data_2, data_valid
  );
endinterface

// File: rtl/data_gen.sv
// Fibonacci / BCD-timer data generator with a programmable tick divider.
module data_gen (
  input logic        clock,
  input logic        reset,
  data_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFib  = 2'd1,
    StTmr  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic [15:0] nxt_q, nxt_d;
  logic [2:0]  div_q, div_d;
  logic [2:0]  prog_q, prog_d;
  logic        valid_q, valid_d;

  logic        cmd;
  logic [16:0] sum;
  logic [15:0] bcd_inc;
  logic [3:0]  nib;
  logic        carry;

  // Any command or update pre-empts a step on the same edge.
  assign cmd = bus.stop | bus.start_f | bus.start_t | bus.update;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: stop beats start_f beats start_t, from any state.
  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = StIdle;
    end else if (bus.start_f) begin
      state_d = StFib;
    end else if (bus.start_t) begin
      state_d = StTmr;
    end
  end

  // Four-digit BCD increment; 9999 wraps to 0000.
  always_comb begin
    bcd_inc = data_q;
    carry   = 1'b1;
    nib     = 4'd0;
    for (int i = 0; i < 4; i++) begin
      nib = data_q[4*i +: 4];
      if (carry) begin
        if (nib == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = nib + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // Output/datapath next values: commands, divider and per-mode step.
  always_comb begin
    data_d  = data_q;
    nxt_d   = nxt_q;
    div_d   = div_q;
    prog_d  = prog_q;
    valid_d = 1'b0;
    sum     = {1'b0, data_q} + {1'b0, nxt_q};
    if (cmd) begin
      if (bus.stop) begin
        data_d = 16'h0000;
        div_d  = 3'd0;
      end else if (bus.start_f) begin
        data_d = 16'h0001;
        nxt_d  = 16'h0001;
        div_d  = 3'd0;
      end else if (bus.start_t) begin
        data_d = 16'h0000;
        div_d  = 3'd0;
      end
      if (bus.update) begin
        prog_d = bus.prog_in;
        div_d  = 3'd0;
      end
    end else if (bus.tick && state_q != StIdle) begin
      if (div_q == prog_q) begin
        div_d   = 3'd0;
        valid_d = 1'b1;
        if (state_q == StFib) begin
          // A 17-bit overflow restarts the sequence instead of showing a truncated term.
          if (sum[16]) begin
            data_d = 16'h0001;
            nxt_d  = 16'h0001;
          end else begin
            data_d = nxt_q;
            nxt_d  = sum[15:0];
          end
        end else begin
          data_d = bcd_inc;
        end
      end else begin
        div_d = div_q + 3'd1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q  <= 16'h0000;
      nxt_q   <= 16'h0001;
      div_q   <= 3'd0;
      prog_q  <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      nxt_q   <= nxt_d;
      div_q   <= div_d;
      prog_q  <= prog_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gen_mod    = state_q;
  assign bus.prog       = prog_q;
  assign bus.data_2     = data_q;
  assign bus.data_valid = valid_q;

endmodule

// File: doc/data_gen.md
DATA_GEN -- requirements
Module: data_gen

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port tick, input, 1 bit: synchronous enable strobe, one clock wide, sets the base step rate.
REQ-004 SHALL have port start_f, input, 1 bit: one-cycle pulse that starts Fibonacci mode.
REQ-005 SHALL have port start_t, input, 1 bit: one-cycle pulse that starts BCD timer mode.
REQ-006 SHALL have port stop, input, 1 bit: one-cycle pulse that returns the block to idle.
REQ-007 SHALL have port update, input, 1 bit: one-cycle pulse that latches prog_in.
REQ-008 SHALL have port prog_in, input, 3 bits: requested step divider value.
REQ-009 SHALL have port gen_mod, output, 2 bits: active mode, where 0 = IDLE, 1 = FIB and 2 = TMR; the value 3 is never driven.
REQ-010 SHALL have port prog, output, 3 bits: currently latched divider value.
REQ-011 SHALL have port data_2, output, 16 bits: generated value, read as four hex/BCD nibbles by the display stage.
REQ-012 SHALL have port data_valid, output, 1 bit: one-cycle pulse on each data_2 change caused by a step.

Function
REQ-013 SHALL implement a state machine with states IDLE, FIB and TMR; gen_mod SHALL be the registered encoding of the current state.
REQ-014 SHALL resolve command priority in any state as stop > start_f > start_t; transitions occur on the same edge that samples the pulse.
REQ-015 SHALL handle stop: next state IDLE; data_2 <= 0x0000; divider counter cleared.
REQ-016 SHALL handle start_f: next state FIB, from any state (restart if already in FIB); data_2 <= 0x0001; internal next-term register <= 0x0001; divider counter cleared.
REQ-017 SHALL handle start_t: next state TMR, from any state (restart if already in TMR); data_2 <= 0x0000; divider counter cleared.
REQ-018 SHALL handle update: prog <= prog_in and the divider counter is cleared, in any state; update is independent of the command pulses.
REQ-019 SHALL implement the divider as a 3-bit counter div_cnt, advanced only on tick when the state is FIB or TMR.
REQ-020 SHALL generate a step when tick = 1 and div_cnt == prog, then div_cnt <= 0; otherwise a tick makes div_cnt <= div_cnt + 1, so one step occurs every prog+1 ticks.
REQ-021 SHALL suppress the step, with no div_cnt change, in any cycle with a command pulse or update; that event takes effect instead.
REQ-022 SHALL take no step in IDLE; there data_2 holds 0x0000 and div_cnt holds 0.
REQ-023 SHALL step FIB with a = data_2, b = next term and 17-bit sum s = a + b: if s[16] = 0 then a <= b, b <= s[15:0]; if s[16] = 1 then a <= 0x0001, b <= 0x0001.
REQ-024 SHALL therefore produce the FIB display sequence 0x0001, 0x0001, 0x0002, 0x0003, 0x0005 ... 0x6FF1, then 0x0001, so 0xB520 is never displayed.
REQ-025 SHALL step TMR as a four-digit BCD increment: nibble 9 rolls to 0 with a carry into the next nibble, and 0x9999 wraps to 0x0000.
REQ-026 SHALL never let any nibble exceed 9 in TMR.
REQ-027 SHALL assert data_valid for exactly the one cycle after an edge at which a step occurred; it is 0 for start, stop and update edges.
REQ-028 SHALL register all outputs directly, with no combinational path from inputs to outputs.

Reset
REQ-029 SHALL, while reset = 0, asynchronously force state IDLE, gen_mod = 0, prog = 0, data_2 = 0x0000, data_valid = 0, div_cnt = 0 and next term = 0x0001.
REQ-030 SHALL, when reset asserts mid-operation, abort immediately with no completion of a pending step; after release the block waits in IDLE for a start pulse.

Verification
REQ-031 SHALL cover: update with prog_in = 0, then start_f, tick every cycle -> gen_mod = 1; data_2 = 0x0001, 0x0001, 0x0002, 0x0003, 0x0005, 0x0008; data_valid pulses once per step.
REQ-032 SHALL cover: FIB run to 0x6FF1, then one more step -> data_2 = 0x0001 with no 0xB520.
REQ-033 SHALL cover: prog = 3, start_t, 8 ticks -> data_2 = 0x0002, with steps on the 4th and 8th tick only; preloading the count to 0x0999, then one step -> 0x1000; 0x9999, then one step -> 0x0000.
REQ-034 SHALL cover: start_f and stop in the same cycle -> stays or goes IDLE with data_2 = 0x0000; start_f and start_t together -> FIB; start_t and tick together -> data_2 = 0x0000 with no step.
REQ-035 SHALL cover: update with prog_in = 5 coinciding with a stepping tick in TMR -> prog = 5, no step, div_cnt = 0, data_valid = 0.
REQ-036 SHALL cover: reset pulled low mid-TMR between clock edges -> all outputs 0 without waiting for an edge; after release, ticks alone leave data_2 = 0x0000 and gen_mod = 0.
